// File: rtl/angle_comb_index_search.sv
// Reverse lookup of an angle-combination ROM: scans entries in ascending order
// and reports the index of the first entry equal to the requested code.
module angle_comb_index_search #(
  parameter int MEM_WIDTH = 16,
  parameter int MEM_DEPTH = 20,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [MEM_WIDTH-1:0] req_code,
  output logic                 rom_enable,
  output logic [AW-1:0]        rom_address,
  input  logic [MEM_WIDTH-1:0] rom_dout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [AW-1:0]        rsp_index
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

  state_t               state;
  state_t               state_next;
  logic [MEM_WIDTH-1:0] code;
  logic                 issuing;    // addresses remain to be issued
  logic                 cmp_valid;  // rom_dout holds the entry at cmp_index
  logic [AW-1:0]        cmp_index;
  logic                 accept;
  logic                 match;
  logic                 scan_end;

  assign accept   = req_valid && req_ready;
  assign match    = cmp_valid && (rom_dout == code);
  assign scan_end = cmp_valid && (cmp_index == LAST_ADDR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: each combinational output is given a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SCAN;
      SCAN:    if (match || scan_end) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    rom_enable = 1'b0;
    case (state)
      IDLE:    req_ready  = !reset;
      SCAN:    rom_enable = issuing;
      default: ;
    endcase
  end

  // Read pipeline: the address issued in one cycle is compared the next,
  // while the following address is already being read.
  always_ff @(posedge clock) begin
    if (reset) begin
      code        <= '0;
      rom_address <= '0;
      issuing     <= 1'b0;
      cmp_valid   <= 1'b0;
      cmp_index   <= '0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_index   <= '0;
    end else if (accept) begin
      code        <= req_code;
      rom_address <= '0;
      issuing     <= 1'b1;
      cmp_valid   <= 1'b0;
    end else if (state == SCAN) begin
      if (match || scan_end) begin
        issuing   <= 1'b0;
        cmp_valid <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_hit   <= match;
        rsp_index <= match ? cmp_index : '1;
      end else begin
        cmp_valid <= issuing;
        cmp_index <= rom_address;
        if (issuing) begin
          if (rom_address == LAST_ADDR) issuing <= 1'b0;
          else                          rom_address <= rom_address + AW'(1);
        end
      end
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_angle_comb_index_search.sv
// Scoreboard bench for angle_comb_index_search with a registered ROM model;
// responses are checked for hit, index, order and latency from accept.
module tb_angle_comb_index_search;

  localparam int W     = 16;
  localparam int DEPTH = 20;
  localparam int AW    = 5;

  typedef struct {
    logic          hit;
    logic [AW-1:0] index;
    int            accept_edge;
    int            lat;
  } exp_t;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_code;
  logic          rom_enable;
  logic [AW-1:0] rom_address;
  logic [W-1:0]  rom_dout;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_hit;
  logic [AW-1:0] rsp_index;

  logic [W-1:0] rom [DEPTH];
  exp_t         sb [$];
  exp_t         mon_e;
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  int           reads    = 0;
  int           bad_addr = 0;
  int           rise_cyc = 0;
  logic         prev_valid = 1'b0;

  angle_comb_index_search #(.MEM_WIDTH(W), .MEM_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_code   (req_code),
    .rom_enable (rom_enable),
    .rom_address(rom_address),
    .rom_dout   (rom_dout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_hit    (rsp_hit),
    .rsp_index  (rsp_index)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Registered ROM: data appears the cycle after an enabled read.
  always @(posedge clock) begin
    if (rom_enable) rom_dout <= rom[rom_address];
  end

  // Response monitor: pops the scoreboard on every handshake.
  always @(negedge clock) begin
    if (rom_enable) begin
      reads++;
      if (int'(rom_address) >= DEPTH) bad_addr++;
    end
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        rise_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL spurious_rsp_valid at cycle %0d with empty scoreboard", cyc);
        end
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        mon_e = sb.pop_front();
        checks++;
        if (rsp_hit !== mon_e.hit) begin
          failures++;
          $display("FAIL rsp_hit got %0b expected %0b", rsp_hit, mon_e.hit);
        end
        checks++;
        if (rsp_index !== mon_e.index) begin
          failures++;
          $display("FAIL rsp_index got %0d expected %0d", rsp_index, mon_e.index);
        end
        checks++;
        if ((rise_cyc - mon_e.accept_edge) !== mon_e.lat) begin
          failures++;
          $display("FAIL latency got %0d expected %0d", rise_cyc - mon_e.accept_edge, mon_e.lat);
        end
      end
      prev_valid = rsp_valid;
    end
  end

  // Drives one request, pushes the reference result, returns after acceptance.
  task automatic send(input logic [W-1:0] c);
    int   budget;
    exp_t e;
    @(negedge clock);
    req_code  = c;
    req_valid = 1'b1;
    budget    = 0;
    while (!req_ready && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL send_accept timeout code %h", c);
      req_valid = 1'b0;
      return;
    end
    e.hit   = 1'b0;
    e.index = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (!e.hit && rom[i] == c) begin
        e.hit   = 1'b1;
        e.index = i[AW-1:0];
      end
    end
    e.lat         = e.hit ? int'(e.index) + 2 : DEPTH + 1;
    e.accept_edge = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int b = 0;
    while (sb.size() != 0 && b < 200) begin
      @(negedge clock);
      b++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s response timeout, %0d outstanding expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks += 6;
    if (rsp_valid !== 1'b0)   begin failures++; $display("FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
    if (rsp_hit !== 1'b0)     begin failures++; $display("FAIL reset_rsp_hit got %b expected 0", rsp_hit); end
    if (rsp_index !== '0)     begin failures++; $display("FAIL reset_rsp_index got %0d expected 0", rsp_index); end
    if (rom_enable !== 1'b0)  begin failures++; $display("FAIL reset_rom_enable got %b expected 0", rom_enable); end
    if (rom_address !== '0)   begin failures++; $display("FAIL reset_rom_address got %0d expected 0", rom_address); end
    if (req_ready !== 1'b0)   begin failures++; $display("FAIL reset_req_ready got %b expected 0", req_ready); end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL idle_req_ready got %b expected 1", req_ready); end
  endtask

  task automatic test_first_entry();
    rsp_ready = 1'b1;
    reads     = 0;
    send(16'h1fdf);
    drain("first_entry");
    checks++;
    if (reads < 1 || reads > 2) begin
      failures++;
      $display("FAIL first_entry_reads got %0d expected 1..2", reads);
    end
  endtask

  task automatic test_last_entry();
    reads    = 0;
    bad_addr = 0;
    send(16'h1b4f);
    drain("last_entry");
    checks += 2;
    if (reads !== 20)   begin failures++; $display("FAIL last_entry_reads got %0d expected 20", reads); end
    if (bad_addr !== 0) begin failures++; $display("FAIL last_entry_addr_range got %0d bad expected 0", bad_addr); end
  endtask

  task automatic test_miss();
    reads    = 0;
    bad_addr = 0;
    send(16'h0000);
    drain("miss");
    checks += 2;
    if (reads !== 20)   begin failures++; $display("FAIL miss_reads got %0d expected 20", reads); end
    if (bad_addr !== 0) begin failures++; $display("FAIL miss_addr_range got %0d bad expected 0", bad_addr); end
  endtask

  task automatic test_backpressure();
    int b = 0;
    rsp_ready = 1'b0;
    send(16'hf3df);
    while (!rsp_valid && b < 100) begin
      @(negedge clock);
      b++;
    end
    checks++;
    if (!rsp_valid) begin failures++; $display("FAIL bp_rsp_valid timeout got 0 expected 1"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks += 4;
      if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got %b expected 1", rsp_valid); end
      if (rsp_hit !== 1'b1)   begin failures++; $display("FAIL bp_hold_hit got %b expected 1", rsp_hit); end
      if (rsp_index !== 5'd8) begin failures++; $display("FAIL bp_hold_index got %0d expected 8", rsp_index); end
      if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_req_ready got %b expected 0", req_ready); end
    end
    @(posedge clock);
    #1 rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_handshake_req_ready got %b expected 0", req_ready); end
    @(negedge clock);
    checks += 2;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_after_req_ready got %b expected 1", req_ready); end
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_after_rsp_valid got %b expected 0", rsp_valid); end
    drain("backpressure");
  endtask

  task automatic test_reset_abort();
    logic seen_valid = 1'b0;
    rsp_ready = 1'b1;
    send(16'h12df);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks += 3;
      if (rom_enable !== 1'b0) begin failures++; $display("FAIL abort_rom_enable got %b expected 0", rom_enable); end
      if (rsp_valid !== 1'b0)  begin failures++; $display("FAIL abort_rsp_valid got %b expected 0", rsp_valid); end
      if (req_ready !== 1'b0)  begin failures++; $display("FAIL abort_req_ready got %b expected 0", req_ready); end
    end
    sb.delete();
    reset = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (rsp_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin failures++; $display("FAIL abort_no_response got rsp_valid expected none"); end
    send(16'h12df);
    drain("after_abort");
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    send(16'h0aff);
    send(16'hff4f);
    drain("back_to_back");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'h3000 + 16'(i) * 16'h0111;
    rom[0]  = 16'h1fdf;
    rom[2]  = 16'h0aff;
    rom[8]  = 16'hf3df;
    rom[12] = 16'h0aff;  // duplicate: only the lowest index may be reported
    rom[15] = 16'h12df;
    rom[16] = 16'hff4f;
    rom[19] = 16'h1b4f;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_code  = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_first_entry();
    test_last_entry();
    test_miss();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/angle_comb_index_search.md
ANGLE_COMB_INDEX_SEARCH -- requirements
Module: angle_comb_index_search

Interface
REQ-001 Parameters SHALL be: MEM_WIDTH, default 16, angle-combination word width; MEM_DEPTH, default 20, number of ROM entries; AW = $clog2(MEM_DEPTH) (derived, 5 at default).
REQ-002 clock  input  1  single clock; all logic updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  lookup request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_code  input  MEM_WIDTH  angle-combination word to locate.
REQ-007 rom_enable  output  1  read enable to the angle-combination ROM.
REQ-008 rom_address  output  AW  ROM read address.
REQ-009 rom_dout  input  MEM_WIDTH  ROM read data, registered by the ROM; valid the cycle after an enabled read.
REQ-010 rsp_valid  output  1  lookup result present.
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 rsp_hit  output  1  1 = code found; 0 = not present.
REQ-013 rsp_index  output  AW  index of the matching entry; all ones on a miss.

Function
REQ-014 The block SHALL perform the reverse mapping of the ROM (word -> address) by scanning ROM entries 0..MEM_DEPTH-1 in ascending order.
REQ-015 FSM states SHALL be IDLE, SCAN and RESP. IDLE->SCAN on req_valid&&req_ready. SCAN->RESP on the first match or after entry MEM_DEPTH-1 is compared. RESP->IDLE on rsp_valid&&rsp_ready.
REQ-016 req_ready SHALL be 1 only in IDLE with reset low; req_code SHALL be latched at the accept edge and held until the scan completes.
REQ-017 Read pipeline: in SCAN, address i is issued in cycle t, and rom_dout is compared with the latched code in cycle t+1 while address i+1 is issued.
REQ-018 rom_enable SHALL be 0 outside SCAN and SHALL never be asserted with an address >= MEM_DEPTH.
REQ-019 One extra read issued in the cycle a match is detected is permitted; the ROM is read-only, so it has no side effect.
REQ-020 The first (lowest-index) match SHALL win; later entries SHALL NOT be compared.
REQ-021 Latency, with accept at edge E0: a hit at index k SHALL raise rsp_valid after edge E(k+2); a miss SHALL raise rsp_valid after edge E(MEM_DEPTH+1), which is E21 at default.
REQ-022 rsp_valid, rsp_hit and rsp_index SHALL be registered and held stable while rsp_valid=1 and rsp_ready=0.
REQ-023 No new request SHALL be accepted in the cycle a response is consumed; req_ready rises the following cycle (one bubble).
REQ-024 Comparison SHALL be a full MEM_WIDTH-bit equality with no masking.

Reset
REQ-025 With reset=1 at an edge: state=IDLE, rsp_valid=0, rsp_hit=0, rsp_index=0, rom_enable=0, rom_address=0, latched code=0; req_ready=0 while reset is high.
REQ-026 Reset during SCAN or RESP SHALL abort the lookup with no response emitted; the first request after reset is handled normally.

Verification
REQ-027 req_code=16'h1fdf accepted at E0 -> after E2: rsp_valid=1, rsp_hit=1, rsp_index=0.
REQ-028 req_code=16'h1b4f -> after E21: rsp_hit=1, rsp_index=19; rom_address never reaches 20.
REQ-029 req_code=16'h0000 -> after E21: rsp_hit=0, rsp_index=5'h1F; exactly 20 enabled reads.
REQ-030 Hit on 16'hf3df (index 8) with rsp_ready=0 for 5 cycles -> outputs stable; req_ready=0 throughout; IDLE one cycle after the handshake.
REQ-031 reset pulsed 3 cycles after accept of 16'h12df -> no rsp_valid; rom_enable=0 during reset; a next request for 16'h12df returns index 15.
REQ-032 Back-to-back requests 16'h0aff then 16'hff4f with rsp_ready=1 -> indices 2 and 16, in order, each at the REQ-021 latency measured from its own accept edge.
